// File: rtl/kbd_pkg.sv
// Shared definitions for the CPC keyboard matrix block.
//   - default matrix geometry (KBD_ROWS x KBD_COLS)
//   - PS/2 set-2 parser state encoding
//   - prefix bytes (E0 extended, F0 break, E1 pause) and the pause skip length
//   - codes that carry no key information (self-test / ack / resend / echo)
//   - map_res_t: result of the {ext, code} -> {row, col} translation
package kbd_pkg;

    localparam int KBD_ROWS = 10;
    localparam int KBD_COLS = 8;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } parse_state_t;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    // Pause is E1 14 77 E1 F0 14 F0 77: seven bytes follow the leading E1.
    localparam logic [2:0] SKIP_LEN = 3'd7;

    localparam logic [7:0] IGN_AA = 8'hAA;
    localparam logic [7:0] IGN_FA = 8'hFA;
    localparam logic [7:0] IGN_FE = 8'hFE;
    localparam logic [7:0] IGN_EE = 8'hEE;

    typedef struct packed {
        logic       hit;
        logic [3:0] row;
        logic [2:0] col;
    } map_res_t;

    function automatic map_res_t key_at(input int row, input int col);
        map_res_t res;
        res.hit = 1'b1;
        res.row = 4'(row);
        res.col = 3'(col);
        return res;
    endfunction

endpackage

// File: rtl/ps2_cpc_map.sv
// Combinational PS/2 set-2 to CPC keyboard matrix translation.
// Ports:
//   ext_i  - code was preceded by E0
//   code_i - final scan byte
//   res_o  - {hit, row, col}; hit = 0 for codes with no CPC key
// Numeric keypad feeds the CPC function keys f0..f9 and f.; backspace is DEL.
module ps2_cpc_map
    import kbd_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] code_i,
    output map_res_t   res_o
);

    always_comb begin
        res_o = '0;
        if (ext_i) begin
            case (code_i)
                8'h75: res_o = key_at(0, 0);   8'h74: res_o = key_at(0, 1);   // up, right
                8'h72: res_o = key_at(0, 2);   8'h6B: res_o = key_at(1, 0);   // down, left
                8'h5A: res_o = key_at(0, 6);   8'h11: res_o = key_at(1, 1);   // kp enter, ralt=copy
                8'h71: res_o = key_at(2, 0);   8'h14: res_o = key_at(2, 7);   // delete=clr, rctrl
                default: res_o = '0;
            endcase
        end else begin
            case (code_i)
                // row 0: f9 f6 f3 f.
                8'h7D: res_o = key_at(0, 3);   8'h74: res_o = key_at(0, 4);
                8'h7A: res_o = key_at(0, 5);   8'h71: res_o = key_at(0, 7);
                // row 1: copy f7 f8 f5 f1 f2 f0
                8'h11: res_o = key_at(1, 1);   8'h6C: res_o = key_at(1, 2);
                8'h75: res_o = key_at(1, 3);   8'h73: res_o = key_at(1, 4);
                8'h69: res_o = key_at(1, 5);   8'h72: res_o = key_at(1, 6);
                8'h70: res_o = key_at(1, 7);
                // row 2: [ return ] f4 shift \ ctrl
                8'h54: res_o = key_at(2, 1);   8'h5A: res_o = key_at(2, 2);
                8'h5B: res_o = key_at(2, 3);   8'h6B: res_o = key_at(2, 4);
                8'h12: res_o = key_at(2, 5);   8'h59: res_o = key_at(2, 5);
                8'h5D: res_o = key_at(2, 6);   8'h14: res_o = key_at(2, 7);
                // row 3: ^ - @ P ; : / .
                8'h55: res_o = key_at(3, 0);   8'h4E: res_o = key_at(3, 1);
                8'h0E: res_o = key_at(3, 2);   8'h4D: res_o = key_at(3, 3);
                8'h4C: res_o = key_at(3, 4);   8'h52: res_o = key_at(3, 5);
                8'h4A: res_o = key_at(3, 6);   8'h49: res_o = key_at(3, 7);
                // row 4: 0 9 O I L K M ,
                8'h45: res_o = key_at(4, 0);   8'h46: res_o = key_at(4, 1);
                8'h44: res_o = key_at(4, 2);   8'h43: res_o = key_at(4, 3);
                8'h4B: res_o = key_at(4, 4);   8'h42: res_o = key_at(4, 5);
                8'h3A: res_o = key_at(4, 6);   8'h41: res_o = key_at(4, 7);
                // row 5: 8 7 U Y H J N space
                8'h3E: res_o = key_at(5, 0);   8'h3D: res_o = key_at(5, 1);
                8'h3C: res_o = key_at(5, 2);   8'h35: res_o = key_at(5, 3);
                8'h33: res_o = key_at(5, 4);   8'h3B: res_o = key_at(5, 5);
                8'h31: res_o = key_at(5, 6);   8'h29: res_o = key_at(5, 7);
                // row 6: 6 5 R T G F B V
                8'h36: res_o = key_at(6, 0);   8'h2E: res_o = key_at(6, 1);
                8'h2D: res_o = key_at(6, 2);   8'h2C: res_o = key_at(6, 3);
                8'h34: res_o = key_at(6, 4);   8'h2B: res_o = key_at(6, 5);
                8'h32: res_o = key_at(6, 6);   8'h2A: res_o = key_at(6, 7);
                // row 7: 4 3 E W S D C X
                8'h25: res_o = key_at(7, 0);   8'h26: res_o = key_at(7, 1);
                8'h24: res_o = key_at(7, 2);   8'h1D: res_o = key_at(7, 3);
                8'h1B: res_o = key_at(7, 4);   8'h23: res_o = key_at(7, 5);
                8'h21: res_o = key_at(7, 6);   8'h22: res_o = key_at(7, 7);
                // row 8: 1 2 esc Q tab A caps Z
                8'h16: res_o = key_at(8, 0);   8'h1E: res_o = key_at(8, 1);
                8'h76: res_o = key_at(8, 2);   8'h15: res_o = key_at(8, 3);
                8'h0D: res_o = key_at(8, 4);   8'h1C: res_o = key_at(8, 5);
                8'h58: res_o = key_at(8, 6);   8'h1A: res_o = key_at(8, 7);
                // row 9: del (bits 0..5 belong to the joystick)
                8'h66: res_o = key_at(9, 7);
                default: res_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/kbd_matrix.sv
// PS/2 set-2 scan byte parser driving an Amstrad CPC keyboard matrix.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   scan_valid/scan_data  - incoming scan byte; scan_ready is high whenever
//                           reset is low (no back-pressure)
//   row_sel               - row select from the PPI
//   row_data              - registered selected row, active-low (0 = pressed);
//                           all ones for row_sel >= ROWS
//   any_key               - registered, high while any key bit is pressed
//   map_err               - one-cycle pulse after an untranslatable final code
//   joy                   - only with KBD_MATRIX_JOY_EN: {fire2, fire1, right,
//                           left, down, up}, active-high, pulls row 9 bits low
// Build option: define KBD_MATRIX_JOY_EN to add the joystick input.
module kbd_matrix
    import kbd_pkg::*;
#(
    parameter int ROWS = KBD_ROWS,
    parameter int COLS = KBD_COLS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scan_valid,
    input  logic [7:0]      scan_data,
    output logic            scan_ready,
    input  logic [3:0]      row_sel,
    output logic [COLS-1:0] row_data,
    output logic            any_key,
    output logic            map_err
`ifdef KBD_MATRIX_JOY_EN
    ,
    input  logic [5:0]      joy
`endif
);

    parse_state_t    state_q, state_d;
    logic [2:0]      skip_q, skip_d;
    logic [COLS-1:0] matrix_q [ROWS];
    logic [COLS-1:0] row_data_q, row_data_d;
    logic            any_key_q, any_key_d;
    logic            map_err_q;

    logic            accept;
    logic            fin, fin_ext, fin_rel;
    logic            map_ok;
    map_res_t        map_res;

    assign scan_ready = ~reset;
    assign accept     = scan_valid & scan_ready;

    // Prefix tracking; fin marks a byte that names a key.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        fin     = 1'b0;
        fin_ext = 1'b0;
        fin_rel = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (scan_data == PFX_E0) begin
                        state_d = EXT;
                    end else if (scan_data == PFX_F0) begin
                        state_d = BRK;
                    end else if (scan_data == PFX_E1) begin
                        state_d = SKIP;
                        skip_d  = SKIP_LEN;
                    end else if (scan_data != IGN_AA && scan_data != IGN_FA &&
                                 scan_data != IGN_FE && scan_data != IGN_EE) begin
                        fin = 1'b1;
                    end
                end
                EXT: begin
                    if (scan_data == PFX_F0) begin
                        state_d = EXT_BRK;
                    end else if (scan_data != PFX_E0) begin
                        fin     = 1'b1;
                        fin_ext = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    fin     = 1'b1;
                    fin_rel = 1'b1;
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    fin     = 1'b1;
                    fin_ext = 1'b1;
                    fin_rel = 1'b1;
                    state_d = IDLE;
                end
                SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    ps2_cpc_map u_map (
        .ext_i  (fin_ext),
        .code_i (scan_data),
        .res_o  (map_res)
    );

    // A table row outside a reduced matrix is treated as a miss.
    assign map_ok = map_res.hit && (int'(map_res.row) < ROWS);

    // Read path: selected row plus any-key summary, registered below.
    always_comb begin
        row_data_d = '1;
        any_key_d  = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_sel == 4'(r)) begin
                row_data_d = matrix_q[r];
            end
            any_key_d = any_key_d | ~(&matrix_q[r]);
        end
`ifdef KBD_MATRIX_JOY_EN
        if (row_sel == 4'd9) begin
            row_data_d[5:0] = row_data_d[5:0] & ~joy;
        end
        any_key_d = any_key_d | (|joy);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            skip_q     <= '0;
            map_err_q  <= 1'b0;
            row_data_q <= '1;
            any_key_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            map_err_q  <= fin & ~map_ok;
            row_data_q <= row_data_d;
            any_key_q  <= any_key_d;
        end
    end

    // One register row per matrix row; press writes 0, release writes 1,
    // so typematic repeats and double releases are naturally idempotent.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    matrix_q[gi] <= '1;
                end else if (fin && map_ok && (int'(map_res.row) == gi)) begin
                    matrix_q[gi][map_res.col] <= fin_rel;
                end
            end
        end
    endgenerate

    assign row_data = row_data_q;
    assign any_key  = any_key_q;
    assign map_err  = map_err_q;

endmodule

// File: tb/tb_kbd_matrix.sv
module tb_kbd_matrix;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_valid;
    logic [7:0] scan_data;
    logic       scan_ready;
    logic [3:0] row_sel;
    logic [7:0] row_data;
    logic       any_key;
    logic       map_err;
`ifdef KBD_MATRIX_JOY_EN
    logic [5:0] joy;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int err_pulses = 0;
    int pulses_base;

    always #5 clk = ~clk;

    kbd_matrix dut (
        .clk        (clk),
        .reset      (reset),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .scan_ready (scan_ready),
        .row_sel    (row_sel),
        .row_data   (row_data),
        .any_key    (any_key),
        .map_err    (map_err)
`ifdef KBD_MATRIX_JOY_EN
        ,
        .joy        (joy)
`endif
    );

    // Count map_err pulses, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (map_err === 1'b1) err_pulses++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    // Caller is at a falling edge; byte is accepted on the next rising edge.
    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_data  = b;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    // Settle one extra edge so the last matrix write reaches row_data.
    task automatic read_row(input logic [3:0] r, input logic [7:0] exp, input string tag);
        row_sel = r;
        @(negedge clk);
        @(negedge clk);
        chk(tag, row_data, exp);
    endtask

    initial begin
        reset      = 1'b1;
        scan_valid = 1'b0;
        scan_data  = 8'h00;
        row_sel    = 4'd0;
`ifdef KBD_MATRIX_JOY_EN
        joy        = 6'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_row_data", row_data, 8'hFF);
        chk("rst_any_key", {7'b0, any_key}, 8'h00);
        chk("rst_map_err", {7'b0, map_err}, 8'h00);
        chk("rst_scan_ready", {7'b0, scan_ready}, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        chk("scan_ready_hi", {7'b0, scan_ready}, 8'h01);

        // A press: row 8 bit 5, visible two edges after acceptance
        row_sel = 4'd8;
        @(negedge clk);
        send(8'h1C);
        chk("a_latency_still_ff", row_data, 8'hFF);
        @(negedge clk);
        chk("a_press_row8", row_data, 8'hDF);
        chk("a_press_any_key", {7'b0, any_key}, 8'h01);
        send(8'hF0); send(8'h1C);
        @(negedge clk);
        chk("a_release_row8", row_data, 8'hFF);
        chk("a_release_any_key", {7'b0, any_key}, 8'h00);

        // Extended up arrow on row 0 bit 0
        row_sel = 4'd0;
        @(negedge clk);
        send(8'hE0); send(8'h75);
        @(negedge clk);
        chk("up_press_row0", row_data, 8'hFE);
        read_row(4'd1, 8'hFF, "up_not_kp8_row1");
        row_sel = 4'd0;
        send(8'hE0); send(8'hF0); send(8'h75);
        @(negedge clk);
        chk("up_release_row0", row_data, 8'hFF);

        // Pause sequence discarded, then space
        pulses_base = err_pulses;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h29);
        read_row(4'd5, 8'h7F, "pause_space_row5");
        read_row(4'd2, 8'hFF, "pause_no_ctrl_row2");
        chk("pause_no_map_err", 8'(err_pulses - pulses_base), 8'h00);
        send(8'hF0); send(8'h29);
        read_row(4'd5, 8'hFF, "space_release_row5");

        // Ignored status codes do not press or error
        pulses_base = err_pulses;
        send(8'hAA); send(8'hFA); send(8'hFE); send(8'hEE);
        @(negedge clk);
        chk("ignored_any_key", {7'b0, any_key}, 8'h00);
        chk("ignored_no_err", 8'(err_pulses - pulses_base), 8'h00);

        // Unmapped code: single map_err pulse, matrix untouched
        pulses_base = err_pulses;
        send(8'h0F);
        chk("unmap_err_high", {7'b0, map_err}, 8'h01);
        @(negedge clk);
        chk("unmap_err_low", {7'b0, map_err}, 8'h00);
        chk("unmap_one_pulse", 8'(err_pulses - pulses_base), 8'h01);
        for (int r = 0; r < 10; r++) begin
            read_row(4'(r), 8'hFF, $sformatf("unmap_row%0d", r));
        end
        chk("unmap_any_key", {7'b0, any_key}, 8'h00);

        // Reset after E0 discards the prefix
        send(8'hE0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_scan_ready", {7'b0, scan_ready}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(8'h75);
        read_row(4'd1, 8'hF7, "midrst_kp8_row1");
        read_row(4'd0, 8'hFF, "midrst_no_up_row0");
        read_row(4'd12, 8'hFF, "rowsel12_ff");
        send(8'hF0); send(8'h75);
        read_row(4'd1, 8'hFF, "kp8_release_row1");

        // Typematic repeat and double release
        pulses_base = err_pulses;
        send(8'h1C); send(8'h1C); send(8'h1C);
        read_row(4'd8, 8'hDF, "typematic_row8");
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h1C);
        read_row(4'd8, 8'hFF, "double_release_row8");
        chk("typematic_no_err", 8'(err_pulses - pulses_base), 8'h00);

        // Backspace is DEL on row 9 bit 7
        send(8'h66);
        read_row(4'd9, 8'h7F, "del_row9");
        send(8'hF0); send(8'h66);
        read_row(4'd9, 8'hFF, "del_release_row9");

`ifdef KBD_MATRIX_JOY_EN
        joy = 6'b010001;
        read_row(4'd9, 8'hEE, "joy_row9");
        chk("joy_any_key", {7'b0, any_key}, 8'h01);
        send(8'h1C);
        read_row(4'd8, 8'hDF, "joy_key_row8");
        send(8'hF0); send(8'h1C);
        joy = 6'b0;
        read_row(4'd9, 8'hFF, "joy_off_row9");
        chk("joy_off_any_key", {7'b0, any_key}, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/kbd_matrix.md
KBD_MATRIX -- requirements
Module: kbd_matrix

Interface
REQ-001 SHALL have parameter ROWS, default 10, number of CPC keyboard matrix rows.
REQ-002 SHALL have parameter COLS, default 8, number of columns per row (bit width of row_data).
REQ-003 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port scan_valid, input, 1, PS/2 scan byte present.
REQ-006 SHALL have port scan_data, input, 8, PS/2 set-2 scan byte.
REQ-007 SHALL have port scan_ready, output, 1, byte accepted on the edge where scan_valid and scan_ready are both high.
REQ-008 SHALL have port row_sel, input, 4, row select from PPI port C[3:0].
REQ-009 SHALL have port row_data, output, COLS, selected row, active-low (0 = pressed), to the PPI input path.
REQ-010 SHALL have port any_key, output, 1, high while any matrix bit is pressed.
REQ-011 SHALL have port map_err, output, 1, one-cycle pulse on an unmapped final code.

Function
REQ-012 SHALL keep a ROWS x COLS matrix of key bits, 1 = released.
REQ-013 SHALL use a parser FSM with states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), and SKIP.
REQ-014 SHALL make these IDLE transitions: E0 -> EXT, F0 -> BRK, E1 -> SKIP with skip counter = 7, AA/FA/FE/EE ignored, any other byte = press and stay in IDLE.
REQ-015 SHALL make these EXT transitions: F0 -> EXT_BRK, E0 ignored, any other byte = extended press -> IDLE.
REQ-016 SHALL make these transitions: BRK, any byte = release -> IDLE; EXT_BRK, any byte = extended release -> IDLE.
REQ-017 SHALL, in SKIP, decrement the counter per accepted byte and return to IDLE when the counter reaches 0, leaving the matrix unchanged (Pause sequence discarded).
REQ-018 SHALL, on a final byte, translate {ext, code} combinationally; on a hit, write the bit (press = 0, release = 1) on the same edge the byte is accepted.
REQ-019 SHALL, on a miss, leave the matrix unchanged and assert map_err for exactly the next cycle.
REQ-020 SHALL keep scan_ready high whenever reset is low, accepting one byte per cycle with no back-pressure.
REQ-021 SHALL register row_data: row_data = matrix[row_sel] one edge after sampling; a matrix write made on edge N is visible on row_data after edge N+1.
REQ-022 SHALL drive row_data = all ones when row_sel >= ROWS.
REQ-023 SHALL register any_key, using the same latency as row_data.
REQ-024 SHALL make a repeated press (typematic) of an already-pressed key idempotent, and a release of a released key a no-op.

Reset
REQ-025 SHALL, while reset is high, hold: all matrix bits 1, FSM = IDLE, skip counter 0, row_data all ones, any_key 0, map_err 0, scan_ready 0.
REQ-026 SHALL, on reset mid-sequence (e.g. after E0 or inside SKIP), discard the partial sequence; the first byte after reset is parsed from IDLE.

Configuration
REQ-027 SHALL, when macro KBD_MATRIX_JOY_EN is defined, add port joy, input, 6, active-high joystick {fire2, fire1, right, left, down, up}.
REQ-028 SHALL, with KBD_MATRIX_JOY_EN defined, force row 9 bit i low on row_data whenever joy[i] is high, ANDed with the matrix contents, with the same one-cycle latency; joy also contributes to any_key.
REQ-029 SHALL, without KBD_MATRIX_JOY_EN, omit the joy port, and row 9 reflects the matrix only.

Structure
REQ-030 SHALL take from shared package kbd_pkg: ROWS/COLS defaults, parser state enum, prefix constants (E0, F0, E1), the skip length 7, ignored-code constants, and the {row, col, hit} map result struct.
REQ-031 SHALL place the translation table in one sub-module ps2_cpc_map (purely combinational lookup: {ext, code} -> {hit, row[3:0], col[2:0]}).

Verification
REQ-032 SHALL cover: send 1C, row_sel = 8 -> row_data = DF two edges later, any_key = 1; then F0 1C -> row_data = FF, any_key = 0.
REQ-033 SHALL cover: send E0 75, row_sel = 0 -> row_data = FE; then E0 F0 75 -> row_data = FF.
REQ-034 SHALL cover: send E1 14 77 E1 F0 14 F0 77 then 29, row_sel = 5 -> only row 5 bit 7 pressed (7F), no map_err, Pause bytes ignored.
REQ-035 SHALL cover: send an unmapped code 0F -> map_err high for exactly one cycle, all rows FF.
REQ-036 SHALL cover: send E0, assert reset for 2 cycles, release reset, send 75 -> treated as non-extended (keypad 8 mapping), not up-arrow; row_sel = 12 -> row_data = FF.
REQ-037 SHALL cover, with KBD_MATRIX_JOY_EN defined: joy = 6'b010001, row_sel = 9 -> row_data = EE; with key 1C also held, row 8 remains DF.
